// File: rtl/encoder_volume_ctrl.sv
// encoder_volume_ctrl
// Converts rotary-encoder steps from an upstream step register into a
// saturating 8-bit volume value that the CPU can also read and write.
//
// Each upstream step is handled by a four-state handshake:
//   IDLE -> ACK -> WAIT_CLR -> UPD -> IDLE.
// ACK pulses rotary_encoder_rd_stb and captures the direction. WAIT_CLR waits
// for the upstream flag to drop. UPD moves the signed sub-detent accumulator
// and, on a full detent, steps the volume.
//
// Optional feature (macro ENC_VOL_ACCEL_EN): a 20-bit saturating interval
// counter measures the time between detents. Detents closer together than
// FAST_CYCLES step the volume by ACCEL_STEP instead of 1. When the macro is
// undefined the counter is absent and the step is always 1.
//
// Ports:
//   clk                   system clock, rising edge
//   reset                 asynchronous, active-high reset
//   enc_state_change      upstream "new step" flag, held until acknowledged
//   rotary_encoder_reg    upstream step register; bit 2 = clockwise
//   rotary_encoder_rd_stb one-cycle acknowledge pulse to upstream
//   vol_wr_stb/vol_wr_data CPU volume write (clamped to VOL_MAX)
//   vol_rd_stb            CPU read strobe, clears vol_changed
//   volume                current volume
//   vol_changed           sticky "volume changed" flag
//   step_pos              signed sub-detent accumulator (debug)
module encoder_volume_ctrl #(
    parameter int unsigned STEPS_PER_DETENT = 4,
    parameter logic [7:0]  VOL_INIT         = 8'd128,
    parameter logic [7:0]  VOL_MAX          = 8'd255,
    parameter logic [19:0] FAST_CYCLES      = 20'd100000,
    parameter int unsigned ACCEL_STEP       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enc_state_change,
    input  logic [7:0]        rotary_encoder_reg,
    output logic              rotary_encoder_rd_stb,
    input  logic              vol_wr_stb,
    input  logic [7:0]        vol_wr_data,
    input  logic              vol_rd_stb,
    output logic [7:0]        volume,
    output logic              vol_changed,
    output logic signed [2:0] step_pos
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR, UPD} state_t;

    localparam logic signed [3:0] SPD = 4'(STEPS_PER_DETENT);

    state_t            state_q, state_d;
    logic              rd_stb_q, rd_stb_d;
    logic              dir_q, dir_d;
    logic signed [2:0] pos_q, pos_d;
    logic [7:0]        vol_q, vol_d;
    logic              chg_q, chg_d;

    logic signed [3:0] pos_nxt;
    logic              det_up, det_dn;
    logic [7:0]        step_sz;

    // Only the direction bit of the upstream register is used.
    logic unused_reg_bits;
    assign unused_reg_bits = ^{rotary_encoder_reg[7:3], rotary_encoder_reg[1:0]};

    // Up step saturating at VOL_MAX; 9-bit sum cannot wrap.
    function automatic logic [7:0] sat_up(input logic [7:0] v, input logic [7:0] s);
        logic [8:0] sum;
        sum = {1'b0, v} + {1'b0, s};
        if (sum > {1'b0, VOL_MAX}) return VOL_MAX;
        return sum[7:0];
    endfunction

    // Down step saturating at 0; 9-bit signed difference cannot wrap.
    function automatic logic [7:0] sat_dn(input logic [7:0] v, input logic [7:0] s);
        logic signed [8:0] diff;
        diff = $signed({1'b0, v}) - $signed({1'b0, s});
        if (diff < 0) return 8'd0;
        return diff[7:0];
    endfunction

`ifdef ENC_VOL_ACCEL_EN
    logic [19:0] ivl_q, ivl_d;

    always_comb begin
        step_sz = (ivl_q < FAST_CYCLES) ? 8'(ACCEL_STEP) : 8'd1;
        ivl_d   = ivl_q;
        if (det_up || det_dn) begin
            ivl_d = 20'd0;
        end else if (ivl_q != 20'hFFFFF) begin
            ivl_d = ivl_q + 20'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ivl_q <= FAST_CYCLES;
        else       ivl_q <= ivl_d;
    end
`else
    always_comb step_sz = 8'd1;
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        vol_d   = vol_q;
        chg_d   = chg_q;
        det_up  = 1'b0;
        det_dn  = 1'b0;
        pos_nxt = {pos_q[2], pos_q} + (dir_q ? 4'sd1 : -4'sd1);

        case (state_q)
            IDLE:     if (enc_state_change) state_d = ACK;
            ACK: begin
                state_d = WAIT_CLR;
                dir_d   = rotary_encoder_reg[2];
            end
            WAIT_CLR: if (!enc_state_change) state_d = UPD;
            UPD: begin
                state_d = IDLE;
                // A coincident CPU write discards this step entirely.
                if (!vol_wr_stb) begin
                    if (pos_nxt == SPD) begin
                        pos_d  = 3'sd0;
                        det_up = 1'b1;
                    end else if (pos_nxt == -SPD) begin
                        pos_d  = 3'sd0;
                        det_dn = 1'b1;
                    end else begin
                        pos_d  = pos_nxt[2:0];
                    end
                end
            end
            default:  state_d = IDLE;
        endcase

        // Acknowledge is high for exactly the cycle spent in ACK.
        rd_stb_d = (state_d == ACK);

        if (det_up)      vol_d = sat_up(vol_q, step_sz);
        else if (det_dn) vol_d = sat_dn(vol_q, step_sz);

        // Sticky flag: a real change wins over a simultaneous read.
        if (vol_d != vol_q) chg_d = 1'b1;
        else if (vol_rd_stb) chg_d = 1'b0;

        // CPU writes do not touch vol_changed.
        if (vol_wr_stb) begin
            vol_d = (vol_wr_data > VOL_MAX) ? VOL_MAX : vol_wr_data;
            pos_d = 3'sd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_stb_q <= 1'b0;
            dir_q    <= 1'b0;
            pos_q    <= 3'sd0;
            vol_q    <= VOL_INIT;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_stb_q <= rd_stb_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
            vol_q    <= vol_d;
            chg_q    <= chg_d;
        end
    end

    assign rotary_encoder_rd_stb = rd_stb_q;
    assign volume                = vol_q;
    assign vol_changed           = chg_q;
    assign step_pos              = pos_q;

endmodule

// File: tb/tb_encoder_volume_ctrl.sv
// Testbench for encoder_volume_ctrl: emulates the upstream step register
// handshake and checks volume, step_pos and vol_changed against hand-computed
// values.
module tb_encoder_volume_ctrl;

    logic              clk = 1'b0;
    logic              reset;
    logic              enc_state_change;
    logic [7:0]        rotary_encoder_reg;
    logic              rotary_encoder_rd_stb;
    logic              vol_wr_stb;
    logic [7:0]        vol_wr_data;
    logic              vol_rd_stb;
    logic [7:0]        volume;
    logic              vol_changed;
    logic signed [2:0] step_pos;

    encoder_volume_ctrl dut (
        .clk                   (clk),
        .reset                 (reset),
        .enc_state_change      (enc_state_change),
        .rotary_encoder_reg    (rotary_encoder_reg),
        .rotary_encoder_rd_stb (rotary_encoder_rd_stb),
        .vol_wr_stb            (vol_wr_stb),
        .vol_wr_data           (vol_wr_data),
        .vol_rd_stb            (vol_rd_stb),
        .volume                (volume),
        .vol_changed           (vol_changed),
        .step_pos              (step_pos)
    );

    always #5 clk = ~clk;

`ifdef ENC_VOL_ACCEL_EN
    localparam int ACC_NEAR = 4;
`else
    localparam int ACC_NEAR = 1;
`endif
    localparam int DN_VOL = 129 - ACC_NEAR;

    int   errors = 0;
    int   checks = 0;
    int   rd_cnt = 0;
    int   vol_e3;
    bit   upd_rd, upd_wr;
    logic [7:0] upd_wdata;

    always @(posedge clk) if (rotary_encoder_rd_stb === 1'b1) rd_cnt++;

    typedef struct {
        bit cw;
        bit rd_before;
        int exp_pos;
        int exp_vol;
        int exp_chg;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        vol_wr_data = d;
        vol_wr_stb  = 1'b1;
        tick;
        vol_wr_stb  = 1'b0;
    endtask

    task automatic rd_pulse;
        vol_rd_stb = 1'b1;
        tick;
        vol_rd_stb = 1'b0;
    endtask

    // One upstream step; flag clears one cycle after the ack. Returns just
    // after the UPD edge; vol_e3 holds the volume seen one cycle earlier.
    task automatic enc_step(input bit cw);
        bit seen;
        seen = 1'b0;
        rotary_encoder_reg = cw ? 8'h07 : 8'hFB;
        enc_state_change   = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick;
            if (rotary_encoder_rd_stb) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("ack_timeout", 0, 1);
            enc_state_change = 1'b0;
            return;
        end
        tick;
        enc_state_change = 1'b0;
        chk("rd_stb_width", int'(rotary_encoder_rd_stb), 0);
        tick;
        vol_e3 = int'(volume);
        if (upd_rd) vol_rd_stb = 1'b1;
        if (upd_wr) begin
            vol_wr_stb  = 1'b1;
            vol_wr_data = upd_wdata;
        end
        tick;
        vol_rd_stb = 1'b0;
        vol_wr_stb = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_vol;
        int base;
        bit seen;

        reset = 1'b1;
        enc_state_change   = 1'b0;
        rotary_encoder_reg = 8'h00;
        vol_wr_stb  = 1'b0;
        vol_wr_data = 8'h00;
        vol_rd_stb  = 1'b0;
        upd_rd = 1'b0;
        upd_wr = 1'b0;
        upd_wdata = 8'h00;

        tbl[0]  = '{1, 0,  1, 128,    0};
        tbl[1]  = '{1, 0,  2, 128,    0};
        tbl[2]  = '{1, 0,  3, 128,    0};
        tbl[3]  = '{1, 0,  0, 129,    1};
        tbl[4]  = '{1, 1,  1, 129,    0};
        tbl[5]  = '{0, 0,  0, 129,    0};
        tbl[6]  = '{0, 0, -1, 129,    0};
        tbl[7]  = '{0, 0, -2, 129,    0};
        tbl[8]  = '{0, 0, -3, 129,    0};
        tbl[9]  = '{0, 0,  0, DN_VOL, 1};
        tbl[10] = '{1, 1,  1, DN_VOL, 0};
        tbl[11] = '{1, 0,  2, DN_VOL, 0};
        tbl[12] = '{1, 0,  3, DN_VOL, 0};
        tbl[13] = '{0, 0,  2, DN_VOL, 0};
        tbl[14] = '{0, 0,  1, DN_VOL, 0};

        tick; tick;
        chk("reset_rd_stb", int'(rotary_encoder_rd_stb), 0);
        chk("reset_step_pos", int'(step_pos), 0);
        chk("reset_volume", int'(volume), 128);
        chk("reset_vol_changed", int'(vol_changed), 0);
        reset = 1'b0;
        tick;

        // Table: detents, reversal, sticky flag, fixed 4-cycle latency.
        base = rd_cnt;
        prev_vol = 128;
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rd_before) rd_pulse;
            enc_step(tbl[i].cw);
            chk($sformatf("latency_vol[%0d]", i), vol_e3, prev_vol);
            chk($sformatf("step_pos[%0d]", i), int'(step_pos), tbl[i].exp_pos);
            chk($sformatf("volume[%0d]", i), int'(volume), tbl[i].exp_vol);
            chk($sformatf("vol_changed[%0d]", i), int'(vol_changed), tbl[i].exp_chg);
            prev_vol = tbl[i].exp_vol;
        end
        chk("rd_stb_pulse_count", rd_cnt - base, 15);

        // Write coincident with UPD wins and discards the step.
        enc_step(1'b1);
        enc_step(1'b1);
        chk("pre_wr_step_pos", int'(step_pos), 3);
        upd_wr = 1'b1;
        upd_wdata = 8'd50;
        enc_step(1'b1);
        upd_wr = 1'b0;
        chk("wr_wins_volume", int'(volume), 50);
        chk("wr_wins_step_pos", int'(step_pos), 0);
        chk("wr_wins_vol_changed", int'(vol_changed), 0);

        // Plain write clears step_pos.
        enc_step(1'b1);
        wr(8'd254);
        chk("wr_volume", int'(volume), 254);
        chk("wr_step_pos", int'(step_pos), 0);
        chk("wr_vol_changed", int'(vol_changed), 0);

        // Upper saturation; flag set once only.
        for (int k = 0; k < 4; k++) enc_step(1'b1);
        chk("sat_hi_volume", int'(volume), 255);
        chk("sat_hi_vol_changed", int'(vol_changed), 1);
        rd_pulse;
        chk("rd_clears", int'(vol_changed), 0);
        for (int k = 0; k < 4; k++) enc_step(1'b1);
        chk("sat_hi_hold_volume", int'(volume), 255);
        chk("sat_hi_hold_vol_changed", int'(vol_changed), 0);
        chk("sat_hi_step_pos", int'(step_pos), 0);

        // Lower saturation.
        wr(8'd0);
        for (int k = 0; k < 4; k++) enc_step(1'b0);
        chk("sat_lo_volume", int'(volume), 0);
        chk("sat_lo_vol_changed", int'(vol_changed), 0);

        // Read strobe in the same cycle as a changing detent.
        wr(8'd10);
        for (int k = 0; k < 3; k++) enc_step(1'b1);
        upd_rd = 1'b1;
        enc_step(1'b1);
        upd_rd = 1'b0;
        chk("rd_vs_set_volume", int'(volume), 10 + ACC_NEAR);
        chk("rd_vs_set_vol_changed", int'(vol_changed), 1);
        wr(8'd200);
        chk("wr_keeps_vol_changed", int'(vol_changed), 1);
        rd_pulse;
        chk("later_rd_clears", int'(vol_changed), 0);

        // Reset asserted while waiting for the upstream flag to clear.
        wr(8'd77);
        enc_step(1'b1);
        rotary_encoder_reg = 8'h07;
        enc_state_change = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick;
            if (rotary_encoder_rd_stb) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort_ack_seen", int'(seen), 1);
        tick;
        enc_state_change = 1'b0;
        reset = 1'b1;
        #2;
        chk("async_reset_volume", int'(volume), 128);
        tick;
        reset = 1'b0;
        base = rd_cnt;
        repeat (10) tick;
        chk("abort_no_rd_stb", rd_cnt - base, 0);
        chk("abort_step_pos", int'(step_pos), 0);
        chk("abort_volume", int'(volume), 128);
        chk("abort_vol_changed", int'(vol_changed), 0);
        enc_step(1'b1);
        chk("after_abort_step_pos", int'(step_pos), 1);

`ifdef ENC_VOL_ACCEL_EN
        // Acceleration: second detent within FAST_CYCLES steps by 4.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        wr(8'd100);
        for (int k = 0; k < 4; k++) enc_step(1'b1);
        chk("accel_first_volume", int'(volume), 101);
        repeat (1000) tick;
        for (int k = 0; k < 4; k++) enc_step(1'b1);
        chk("accel_second_volume", int'(volume), 105);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_volume_ctrl.md
ENCODER_VOLUME_CTRL -- requirements
Module: encoder_volume_ctrl

Interface
REQ-001 Parameter STEPS_PER_DETENT, default 4: encoder state changes per mechanical detent.
REQ-002 Parameter VOL_INIT, default 8'd128: volume value after reset.
REQ-003 Parameter VOL_MAX, default 8'd255: upper saturation limit; the lower limit is fixed at 0.
REQ-004 Parameter FAST_CYCLES, default 20'd100000: detent interval, in clk cycles, below which acceleration applies.
REQ-005 Parameter ACCEL_STEP, default 4: volume increment per detent when accelerated.
REQ-006 clk  input  1  single system clock; all logic is on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 enc_state_change  input  1  upstream "new encoder step" flag; stays high until cleared by rotary_encoder_rd_stb.
REQ-009 rotary_encoder_reg  input  8  upstream step register; bit 2 = clockwise, bits 1:0 = BA level.
REQ-010 rotary_encoder_rd_stb  output  1  one-cycle pulse that acknowledges and clears the upstream flag.
REQ-011 vol_wr_stb  input  1  CPU volume write strobe.
REQ-012 vol_wr_data  input  8  CPU write value.
REQ-013 vol_rd_stb  input  1  CPU read strobe; clears vol_changed.
REQ-014 volume  output  8  current volume.
REQ-015 vol_changed  output  1  sticky flag, set when volume changes.
REQ-016 step_pos  output  3  signed sub-detent accumulator, for debug.

Function
REQ-017 The FSM SHALL have four states: IDLE, ACK, WAIT_CLR and UPD.
- IDLE -> ACK when enc_state_change is 1.
- ACK -> WAIT_CLR unconditionally.
- WAIT_CLR -> UPD when enc_state_change is 0.
- UPD -> IDLE unconditionally.
REQ-018 rotary_encoder_rd_stb SHALL be registered and high exactly one cycle, while in ACK; in ACK, dir SHALL latch rotary_encoder_reg[2].
REQ-019 In UPD, step_pos SHALL change by +1 if dir=1 and by -1 if dir=0.
REQ-020 When step_pos would reach +STEPS_PER_DETENT, step_pos SHALL become 0 and a detent-up event SHALL occur; reaching -STEPS_PER_DETENT SHALL give step_pos 0 and a detent-down event.
REQ-021 A reversal mid-detent SHALL move step_pos back toward 0 without producing an event.
REQ-022 A detent event SHALL change volume by the step size, saturating:
- up: min(volume+step, VOL_MAX);
- down: max(volume-step, 0);
- arithmetic SHALL use 9 bits, with no wrap.
REQ-023 vol_changed SHALL be set only when the volume value actually differs; a detent at the limit SHALL leave vol_changed unchanged.
REQ-024 vol_changed SHALL clear on vol_rd_stb; a simultaneous set and vol_rd_stb SHALL leave it set.
REQ-025 vol_wr_stb SHALL, next cycle:
- load volume with min(vol_wr_data, VOL_MAX);
- clear step_pos to 0;
- leave vol_changed unchanged.
REQ-026 If vol_wr_stb coincides with UPD, the write SHALL win and that step SHALL be discarded.
REQ-027 Latency SHALL be fixed: enc_state_change rising to volume update takes 4 cycles when the upstream flag clears one cycle after the ack.
REQ-028 A new upstream step arriving during UPD SHALL be served by the next IDLE->ACK pass, with no loss.

Reset
REQ-029 On reset the block SHALL enter IDLE with:
- rotary_encoder_rd_stb=0;
- step_pos=0;
- dir=0;
- volume=VOL_INIT;
- vol_changed=0;
- interval counter=FAST_CYCLES (saturated).
REQ-030 Reset asserted mid-handshake SHALL abort the handshake; no partial update SHALL occur.

Configuration
REQ-031 With ENC_VOL_ACCEL_EN defined:
- a 20-bit saturating interval counter SHALL increment each cycle;
- the counter SHALL reset to 0 on each detent event;
- an event while counter < FAST_CYCLES SHALL use step ACCEL_STEP, otherwise step 1.
REQ-032 With ENC_VOL_ACCEL_EN undefined, the counter SHALL be absent and the step SHALL always be 1.

Verification
REQ-033 Reset, then 4 clockwise upstream steps -> four rd_stb pulses; volume 128->129; vol_changed=1; step_pos=0.
REQ-034 3 CW steps then 2 CCW steps -> step_pos goes 1,2,3,2,1; volume stays 128; vol_changed=0.
REQ-035 vol_wr_data=8'd254, then 8 CW steps spaced >FAST_CYCLES -> volume 255, then stays 255; vol_changed set once only.
REQ-036 ENC_VOL_ACCEL_EN defined, 2 CW detents 1000 cycles apart from volume 100 -> volume 101, then 105.
REQ-037 vol_rd_stb in the same cycle as a detent that changes volume -> vol_changed=1; a later vol_rd_stb -> 0.
REQ-038 Reset asserted in WAIT_CLR -> FSM in IDLE, volume=128, no further rd_stb until a new enc_state_change.
